// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: next-PC source select and
// the fixed-priority decode of the control inputs.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET
  } pc_sel_e;

  // Priority: stall > ret > call > jump > branch > sequential.
  function automatic pc_sel_e pc_select(input logic en,
                                        input logic ret_valid,
                                        input logic call_valid,
                                        input logic jump_valid,
                                        input logic branch_valid);
    if (!en)               return SEL_HOLD;
    else if (ret_valid)    return SEL_RET;
    else if (call_valid)   return SEL_CALL;
    else if (jump_valid)   return SEL_JUMP;
    else if (branch_valid) return SEL_BRANCH;
    else                   return SEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack with saturating count and registered
// single-cycle overflow/underflow pulses.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic [ADDR_W-1:0]                data_i,
  output logic [ADDR_W-1:0]                top_o,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   count_o,
  output logic                             overflow_o,
  output logic                             underflow_o
);

  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              full, empty;

  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign empty   = (cnt_q == '0);
  // ptr_q is the next write slot; the newest entry sits one slot behind it.
  assign ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (push_i) begin
      ptr_d = ptr_inc;
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = ptr_dec;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Writing at a full stack overwrites the oldest entry in place.
  always_ff @(posedge clk) begin
    if (!rst && push_i) mem_q[ptr_q] <= data_i;
  end

  assign top_o       = mem_q[ptr_dec];
  assign count_o     = cnt_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: stall, relative branch, absolute jump and
// call/return through an internal return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned STEP       = 1,
  parameter int unsigned RAS_DEPTH  = 4,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           branch_valid,
  input  logic [ADDR_W-1:0]              branch_offset,
  input  logic                           jump_valid,
  input  logic                           call_valid,
  input  logic                           ret_valid,
  input  logic [ADDR_W-1:0]              jump_target,
  output logic [ADDR_W-1:0]              pc,
  output logic [ADDR_W-1:0]              pc_next,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_seq, ras_top;

  always_comb sel = pc_select(en, ret_valid, call_valid, jump_valid, branch_valid);

  assign pc_seq = pc_q + ADDR_W'(STEP);

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .rst        (rst),
    .push_i     (sel == SEL_CALL),
    .pop_i      (sel == SEL_RET),
    .data_i     (pc_seq),
    .top_o      (ras_top),
    .count_o    (ras_count),
    .overflow_o (ras_overflow),
    .underflow_o(ras_underflow)
  );

  // Offset is already ADDR_W wide, so plain addition gives sign-extended
  // modulo-2^ADDR_W arithmetic.
  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      SEL_HOLD:   pc_d = pc_q;
      SEL_SEQ:    pc_d = pc_seq;
      SEL_BRANCH: pc_d = pc_q + branch_offset;
      SEL_JUMP:   pc_d = jump_target;
      SEL_CALL:   pc_d = jump_target;
      SEL_RET:    pc_d = (ras_count != '0) ? ras_top : pc_seq;
      default:    pc_d = pc_q;
    endcase
    if (rst) pc_d = ADDR_W'(RESET_ADDR);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= ADDR_W'(RESET_ADDR);
    else     pc_q <= pc_d;
  end

  assign pc      = pc_q;
  assign pc_next = pc_d;

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer (ADDR_W=6, STEP=1, RAS_DEPTH=4).
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, branch_valid, jump_valid, call_valid, ret_valid;
  logic [5:0] branch_offset, jump_target, pc, pc_next;
  logic [2:0] ras_count;
  logic       ras_overflow, ras_underflow;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W    (6),
    .STEP      (1),
    .RAS_DEPTH (4),
    .RESET_ADDR(0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .branch_valid (branch_valid),
    .branch_offset(branch_offset),
    .jump_valid   (jump_valid),
    .call_valid   (call_valid),
    .ret_valid    (ret_valid),
    .jump_target  (jump_target),
    .pc           (pc),
    .pc_next      (pc_next),
    .ras_count    (ras_count),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  typedef struct {
    string      tag;
    logic       r, e, b, j, c, t;
    logic [5:0] off, tgt, pc;
    logic [2:0] cnt;
    logic       ovf, unf;
  } vec_t;

  typedef struct {
    int         idx;
    string      tag;
    logic [5:0] pc;
    logic [2:0] cnt;
    logic       ovf, unf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(string tag, logic r, logic e, logic b, logic j,
                              logic c, logic t, logic [5:0] off, logic [5:0] tgt,
                              logic [5:0] epc, logic [2:0] cnt, logic ovf, logic unf);
    vec_t v;
    v.tag = tag; v.r = r; v.e = e; v.b = b; v.j = j; v.c = c; v.t = t;
    v.off = off; v.tgt = tgt; v.pc = epc; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  function automatic void seq(string tag, logic [5:0] epc, logic [2:0] cnt);
    add(tag, 0, 1, 0, 0, 0, 0, 6'd0, 6'd0, epc, cnt, 0, 0);
  endfunction

  task automatic chk(string name, int idx, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s vec%0d: got %0d expected %0d", name, idx, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; branch_valid = 1'b0; jump_valid = 1'b0;
    call_valid = 1'b0; ret_valid = 1'b0; branch_offset = '0; jump_target = '0;

    add("reset", 1, 0, 0, 0, 0, 0, 6'd0, 6'd0, 6'd0, 3'd0, 0, 0);
    for (int k = 1; k <= 65; k++) seq("free_run", 6'(k % 64), 3'd0);
    for (int k = 2; k <= 5; k++) seq("to5", 6'(k), 3'd0);
    for (int k = 0; k < 3; k++)
      add("stall", 0, 0, 0, 0, 1, k == 0, 6'd0, 6'd20, 6'd5, 3'd0, 0, 0);
    seq("unstall", 6'd6, 3'd0);
    for (int k = 7; k <= 10; k++) seq("to10", 6'(k), 3'd0);
    add("br_neg3", 0, 1, 1, 0, 0, 0, 6'h3D, 6'd0, 6'd7, 3'd0, 0, 0);
    add("jump62", 0, 1, 0, 1, 0, 0, 6'd0, 6'd62, 6'd62, 3'd0, 0, 0);
    add("br_wrap", 0, 1, 1, 0, 0, 0, 6'd4, 6'd0, 6'd2, 3'd0, 0, 0);
    add("jmp_br", 0, 1, 1, 1, 0, 0, 6'd10, 6'd3, 6'd3, 3'd0, 0, 0);
    add("call40", 0, 1, 0, 0, 1, 0, 6'd0, 6'd40, 6'd40, 3'd1, 0, 0);
    add("ret4", 0, 1, 0, 0, 0, 1, 6'd0, 6'd0, 6'd4, 3'd0, 0, 0);
    for (int k = 5; k <= 8; k++) seq("to8", 6'(k), 3'd0);
    add("call_ret", 0, 1, 0, 0, 1, 1, 6'd0, 6'd50, 6'd9, 3'd0, 0, 1);
    seq("unf_clr", 6'd10, 3'd0);
    add("jump1", 0, 1, 0, 1, 0, 0, 6'd0, 6'd1, 6'd1, 3'd0, 0, 0);
    add("call11", 0, 1, 0, 0, 1, 0, 6'd0, 6'd11, 6'd11, 3'd1, 0, 0);
    add("call21", 0, 1, 0, 0, 1, 0, 6'd0, 6'd21, 6'd21, 3'd2, 0, 0);
    add("call31", 0, 1, 0, 0, 1, 0, 6'd0, 6'd31, 6'd31, 3'd3, 0, 0);
    add("call41", 0, 1, 0, 0, 1, 0, 6'd0, 6'd41, 6'd41, 3'd4, 0, 0);
    add("call_ovf", 0, 1, 0, 0, 1, 0, 6'd0, 6'd50, 6'd50, 3'd4, 1, 0);
    add("ret42", 0, 1, 0, 0, 0, 1, 6'd0, 6'd0, 6'd42, 3'd3, 0, 0);
    add("ret32", 0, 1, 0, 0, 0, 1, 6'd0, 6'd0, 6'd32, 3'd2, 0, 0);
    add("ret22", 0, 1, 0, 0, 0, 1, 6'd0, 6'd0, 6'd22, 3'd1, 0, 0);
    add("ret12", 0, 1, 0, 0, 0, 1, 6'd0, 6'd0, 6'd12, 3'd0, 0, 0);
    add("ret_unf", 0, 1, 0, 0, 0, 1, 6'd0, 6'd0, 6'd13, 3'd0, 0, 1);
    add("nest1", 0, 1, 0, 0, 1, 0, 6'd0, 6'd20, 6'd20, 3'd1, 0, 0);
    add("nest2", 0, 1, 0, 0, 1, 0, 6'd0, 6'd30, 6'd30, 3'd2, 0, 0);
    add("mid_rst", 1, 1, 0, 1, 0, 0, 6'd0, 6'd9, 6'd0, 3'd0, 0, 0);
    add("ret_post_rst", 0, 1, 0, 0, 0, 1, 6'd0, 6'd0, 6'd1, 3'd0, 0, 1);
    add("stall_clr", 0, 0, 0, 0, 0, 1, 6'd0, 6'd0, 6'd1, 3'd0, 0, 0);
    seq("final", 6'd2, 3'd0);

    foreach (vecs[i]) begin
      exp_t e;
      exp_t got;
      @(negedge clk);
      rst = vecs[i].r; en = vecs[i].e; branch_valid = vecs[i].b;
      jump_valid = vecs[i].j; call_valid = vecs[i].c; ret_valid = vecs[i].t;
      branch_offset = vecs[i].off; jump_target = vecs[i].tgt;
      #1;
      chk({vecs[i].tag, ".pc_next"}, i, pc_next, vecs[i].pc);
      e.idx = i; e.tag = vecs[i].tag; e.pc = vecs[i].pc; e.cnt = vecs[i].cnt;
      e.ovf = vecs[i].ovf; e.unf = vecs[i].unf;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard vec%0d: got empty queue expected entry", i);
      end else begin
        got = sb.pop_front();
        chk({got.tag, ".pc"},  got.idx, pc,            got.pc);
        chk({got.tag, ".cnt"}, got.idx, ras_count,     got.cnt);
        chk({got.tag, ".ovf"}, got.idx, ras_overflow,  got.ovf);
        chk({got.tag, ".unf"}, got.idx, ras_underflow, got.unf);
      end
    end

    chk("scoreboard_drain", 0, sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program counter for the CPU fetch stage, successor to the fixed 5-bit free-running counter. It supports configurable width, stall, PC-relative branch, absolute jump, and call/return through an internal return-address stack (RAS). It sits between the control unit and the instruction memory address port, and exposes the current and next PC plus RAS status.

Parameters:
ADDR_W, 6, PC width in bits; all PC arithmetic is modulo 2^ADDR_W.
STEP, 1, sequential increment added to pc each enabled cycle.
RAS_DEPTH, 4, number of return-address stack entries (>=1).
RESET_ADDR, 0, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
en  input  1  advance enable; 0 = stall (hold all state).
branch_valid  input  1  take PC-relative branch.
branch_offset  input  ADDR_W  signed two's-complement offset added to pc.
jump_valid  input  1  absolute jump to jump_target.
call_valid  input  1  jump to jump_target and push return address.
ret_valid  input  1  pop RAS into pc.
jump_target  input  ADDR_W  target for jump and call.
pc  output  ADDR_W  current program counter (registered).
pc_next  output  ADDR_W  combinational value pc takes at next edge.
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries.
ras_overflow  output  1  registered 1-cycle pulse: call pushed while full.
ras_underflow  output  1  registered 1-cycle pulse: ret while empty.

Behaviour:
- Reset (rst=1 at edge): pc=RESET_ADDR, ras_count=0, ras_overflow=0, ras_underflow=0. Overrides all other inputs; legal at any time, discards RAS contents.
- en=0: pc, RAS and ras_count hold; control inputs are ignored; pc_next=pc; both flags are 0 the following cycle.
- en=1, fixed priority ret > call > jump > branch > sequential:
  - ret, ras_count>0: pc <= top entry; ras_count-1.
  - ret, ras_count=0: pc <= pc+STEP; ras_underflow=1 for one cycle; count stays 0.
  - call: pc <= jump_target; push pc+STEP. If ras_count=RAS_DEPTH, the oldest entry is discarded (circular), count stays RAS_DEPTH, and ras_overflow=1 for one cycle.
  - jump: pc <= jump_target.
  - branch: pc <= pc + sign-extended branch_offset, truncated to ADDR_W.
  - none: pc <= pc+STEP, wrapping (2^ADDR_W-1 -> 0 for STEP=1).
- Simultaneous controls: only the highest-priority one acts; lower ones are ignored with no side effects (e.g. call+ret = pure ret, no push).
- Latency: a control sampled at edge N appears on pc after edge N; pc_next reflects it in the same cycle, zero-delay from inputs.
- Flags are exclusive and deasserted in every cycle that has no triggering event.

Decomposition:
- Package pc_pkg: enum pc_sel_e {SEL_HOLD, SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_CALL, SEL_RET}; a function computing the priority select from en and the valid inputs.
- Sub-module ras_stack: circular LIFO with push/pop/count/overflow/underflow, parameters ADDR_W and RAS_DEPTH. The top level holds the pc register, the next-PC mux and the adder.

Test Plan:
1. Reset, then en=1 with no controls for 65 cycles -> pc 0,1,...,63,0,1; flags stay 0.
2. At pc=5, en=0 for 3 cycles -> pc holds 5 and pc_next=5; first enabled cycle after -> pc=6.
3. At pc=10, branch offset -3 (6'h3D) -> pc=7. At pc=62, offset +4 -> pc=2 (wrap).
4. At pc=3, call target 40 -> pc=40, ras_count=1. Then ret -> pc=4, ras_count=0. Call+ret together at pc=8 with empty RAS -> pc=9, ras_underflow pulse, no push.
5. Calls at pc=1,11,21,31,41 with RAS_DEPTH=4 -> overflow pulse on the 5th call only, ras_count=4. Five rets -> pc 42,32,22,12, then 5th ret gives underflow pulse and pc=prev+1.
6. Two nested calls (ras_count=2), then rst asserted mid-stream -> next cycle pc=0, ras_count=0. Following ret -> ras_underflow=1, pc=1.
